i2s_tx: RTL

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/audio_pkg.sv | 26 ++
 rtl/sample_fifo.sv | 66 ++++++
 rtl/i2s_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// audio_pkg: constants and helpers shared by the audio blocks.
//   I2S_SLOT_BITS  - BCLK periods per channel slot
//   I2S_FRAME_BITS - BCLK periods per stereo frame (left + right)
//   sat_signed     - clamps a signed value to the range of a w-bit signed word
package audio_pkg;

  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;

  // Works on a 64-bit carrier so one function serves every input/output
  // width; the caller keeps only the low w bits of the result.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] x,
                                                    input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi)
      sat_signed = hi;
    else if (x < lo)
      sat_signed = lo;
    else
      sat_signed = x;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO holding converted audio samples.
// Ports:
//   clk, rst           - clock, synchronous active-high reset (pointers only)
//   i_wr_en, i_wr_data - write strobe and data; ignored when full unless a
//                        read happens in the same cycle
//   i_rd_en            - pop strobe; ignored when empty
//   o_rd_data          - head entry (valid while o_empty is low)
//   o_full, o_empty    - occupancy flags
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_empty;
  logic             w_full;
  logic             w_do_rd;
  logic             w_do_wr;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
              (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_do_rd = i_rd_en && !w_empty;
    // A read in the same cycle frees a slot, so a full FIFO can still accept.
    w_do_wr = i_wr_en && (!w_full || w_do_rd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr)
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_rd)
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_wr)
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full    = w_full;
  assign o_empty   = w_empty;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: mono-to-stereo I2S transmitter.
// Samples are saturated to SAMPLE_WIDTH on write, queued in sample_fifo, and
// sent MSB first on both channels of each 64-BCLK frame with the standard
// one-BCLK MSB delay and zero padding to the 32-bit slot.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   sample_in        - signed DATA_WIDTH-bit mono sample
//   sample_in_valid  - single-cycle write strobe, no backpressure
//   i2s_bclk         - bit clock (clk / BCLK_DIV); data changes on its fall
//   i2s_lrclk        - word select, 0 = left, 1 = right
//   i2s_sdata        - serial data
//   overflow         - sticky, set when a write is dropped on a full FIFO
//   underrun         - one-cycle pulse when a frame starts with the FIFO empty
//   underrun_count   - saturating 16-bit underrun counter, present only when
//                      I2S_TX_UNDERRUN_CNT_EN is defined
module i2s_tx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int SAMPLE_WIDTH = 24,
  parameter int BCLK_DIV     = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  input  logic                         sample_in_valid,
  output logic                         i2s_bclk,
  output logic                         i2s_lrclk,
  output logic                         i2s_sdata,
  output logic                         overflow,
`ifdef I2S_TX_UNDERRUN_CNT_EN
  output logic                         underrun,
  output logic [15:0]                  underrun_count
`else
  output logic                         underrun
`endif
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(I2S_FRAME_BITS);
  localparam int POS_W = $clog2(I2S_SLOT_BITS);
  localparam int IDX_W = $clog2(SAMPLE_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);

  logic [DIV_W-1:0]        r_div_cnt;
  logic [BIT_W-1:0]        r_bit_cnt;
  logic                    r_bclk;
  logic                    r_lrclk;
  logic                    r_sdata;
  logic                    r_overflow;
  logic                    r_underrun;
  logic [SAMPLE_WIDTH-1:0] r_sh_l;
  logic [SAMPLE_WIDTH-1:0] r_sh_r;

  logic [DIV_W-1:0]        w_div_nxt;
  logic                    w_tick;
  logic [BIT_W-1:0]        w_bit_nxt;
  logic [POS_W-1:0]        w_pos;
  logic                    w_frame_start;
  logic                    w_pop;
  logic                    w_fifo_wr;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [SAMPLE_WIDTH-1:0] w_fifo_wr_data;
  logic [SAMPLE_WIDTH-1:0] w_fifo_rd_data;
  logic [SAMPLE_WIDTH-1:0] w_sh_sel;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_pos_live;
  logic                    w_sd_nxt;

  // ---- input stage: saturate and queue ----
  assign w_fifo_wr_data = SAMPLE_WIDTH'(sat_signed(64'(sample_in), SAMPLE_WIDTH));

  sample_fifo #(
    .WIDTH (SAMPLE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (w_fifo_wr_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_rd_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // ---- timing and serializer select ----
  always_comb begin
    w_tick        = (r_div_cnt == DIV_LAST);
    w_div_nxt     = w_tick ? '0 : r_div_cnt + DIV_W'(1);
    w_bit_nxt     = r_bit_cnt + BIT_W'(1);
    w_pos         = w_bit_nxt[POS_W-1:0];
    w_frame_start = w_tick && (w_bit_nxt == '0);
    // The pop happens before the write is seen, so a write landing on an
    // empty FIFO at frame start waits for the next frame.
    w_pop         = w_frame_start && !w_fifo_empty;
    w_fifo_wr     = sample_in_valid && (!w_fifo_full || w_pop);
    // Slot position 0 is the one-BCLK delay; positions past the sample are pad.
    w_pos_live    = (w_pos != '0) && (32'(w_pos) <= 32'(SAMPLE_WIDTH));
    w_idx         = IDX_W'(SAMPLE_WIDTH - int'(w_pos));
    w_sh_sel      = w_bit_nxt[BIT_W-1] ? r_sh_r : r_sh_l;
    w_sd_nxt      = w_pos_live ? w_sh_sel[w_idx] : 1'b0;
  end

  // ---- output stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt  <= '0;
      r_bit_cnt  <= '1;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_sdata    <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
      r_sh_l     <= '0;
      r_sh_r     <= '0;
    end else begin
      r_div_cnt  <= w_div_nxt;
      r_bclk     <= (w_div_nxt >= DIV_HALF);
      r_underrun <= w_frame_start && w_fifo_empty;
      if (sample_in_valid && !w_fifo_wr)
        r_overflow <= 1'b1;
      if (w_tick) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= w_bit_nxt[BIT_W-1];
        r_sdata   <= w_sd_nxt;
      end
      if (w_frame_start) begin
        r_sh_l <= w_pop ? w_fifo_rd_data : '0;
        r_sh_r <= w_pop ? w_fifo_rd_data : '0;
      end
    end
  end

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_ur_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_ur_cnt <= '0;
    else if (w_frame_start && w_fifo_empty && (r_ur_cnt != 16'hFFFF))
      r_ur_cnt <= r_ur_cnt + 16'd1;
  end

  assign underrun_count = r_ur_cnt;
`endif

  assign i2s_bclk  = r_bclk;
  assign i2s_lrclk = r_lrclk;
  assign i2s_sdata = r_sdata;
  assign overflow  = r_overflow;
  assign underrun  = r_underrun;

endmodule
